cmd_packet_tx: RTL and testbench
================================

// Module: cmd_packet_tx
// PURPOSE
//  Upstream feeder for the UART transmitter. Latches a 16-bit command and frames it as a 4-byte packet.
//  Packet bytes, in order: SYNC, cmd[15:8], cmd[7:0], checksum.
//  Drives the transmitter's trmt/tx_data one byte at a time and paces on its tx_done.
//  Flags completion (cmd_snt) or a stalled transmitter (tx_err) to the control logic.
// PARAMETERS
//  SYNC_BYTE  8'hA5     first byte of every packet
//  CHK_EN     1         1: send checksum byte (4-byte packet); 0: omit it (3-byte packet)
//  TIMEOUT    16'd30000 max clk cycles to wait for each byte's tx_done rise (1 byte = 26050 clk)
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   asynchronous active-low reset
//  snd_cmd  in   1   1-cycle request: send cmd; honoured only in IDLE
//  cmd      in   16  command word; sampled in the cycle snd_cmd is accepted
//  tx_done  in   1   from transmitter: level, set at end of byte, cleared after its next trmt
//  trmt     out  1   1-cycle start pulse to transmitter
//  tx_data  out  8   byte to transmit; valid while trmt=1, held until next trmt
//  busy     out  1   high from the cycle after acceptance until return to IDLE
//  cmd_snt  out  1   sticky: last byte completed; cleared when the next snd_cmd is accepted
//  tx_err   out  1   sticky: timeout abort; cleared when the next snd_cmd is accepted
// BEHAVIOUR
//  Single clock, asynchronous active-low reset.
//  Reset values: state=IDLE, trmt=0, tx_data=8'h00, busy=0, cmd_snt=0, tx_err=0.
//  Reset clears byte_idx, tmo_cnt and tx_done_ff to 0. Reset mid-packet aborts with no further trmt.
//  Checksum: chk = ~(cmd[15:8] + cmd[7:0]). 8-bit sum, carry discarded; SYNC is not included.
//    The checksum is computed from the latched cmd only.
//  Edge detect: tx_done_ff <= tx_done; done_rise = tx_done & ~tx_done_ff.
//    Only done_rise advances the FSM. A stale high tx_done left over from the previous byte is ignored.
//  State machine, 3 states, registered state:
//   IDLE: snd_cmd=1 -> latch cmd, byte_idx=0, cmd_snt=0, tx_err=0 -> LOAD. snd_cmd=0 -> stay.
//   LOAD: one cycle only. trmt=1 (Moore decode of state).
//     tx_data <= byte[byte_idx], registered and entering LOAD. tmo_cnt=0 -> WAIT.
//   WAIT: tmo_cnt increments each cycle.
//     done_rise and byte_idx==LAST -> cmd_snt=1 -> IDLE.
//     done_rise and byte_idx<LAST -> byte_idx+1 -> LOAD.
//     tmo_cnt==TIMEOUT-1 without done_rise -> tx_err=1 -> IDLE.
//     done_rise in the same cycle as the timeout: done_rise wins.
//  LAST = 3 if CHK_EN else 2. byte_idx is 2 bits; byte[0..3] = {SYNC_BYTE, cmd_hi, cmd_lo, chk}.
//  Latency: snd_cmd accepted in cycle N -> busy=1 and first trmt in cycle N+1.
//    After a non-final done_rise in cycle M -> next trmt in cycle M+1.
//  busy = (state != IDLE). snd_cmd while busy is dropped silently; cmd_reg does not change.
//  snd_cmd in the same cycle the FSM returns to IDLE is dropped. It is accepted from the first cycle in IDLE.
//  Exactly LAST+1 trmt pulses per successful packet, and never two trmt without a done_rise between them.
//  cmd may change freely after acceptance; packet bytes come from cmd_reg.
// TESTING
//  1 Basic: cmd=16'h1234, CHK_EN=1, real transmitter in loop.
//    -> tx_data sequence A5,12,34,B9; 4 trmt pulses; then cmd_snt=1, busy=0.
//  2 Checksum wrap: cmd=16'hFF02 -> chk=8'hFE; cmd=16'h0000 -> chk=8'hFF.
//    Decode the TX line with a serial monitor and compare bytes.
//  3 Busy drop: pulse snd_cmd with cmd=16'hBEEF midway through the 2nd byte of a 16'h1234 packet.
//    -> packet stays A5,12,34,B9; no extra trmt; cmd_snt=1 at end.
//  4 Timeout: model that never raises tx_done, TIMEOUT=16'd100.
//    -> one trmt, then tx_err=1, busy=0 exactly 100 cycles after WAIT entry.
//    A following snd_cmd clears tx_err.
//  5 Stale done: hold tx_done=1 entering WAIT, drop it 1 cycle later, re-raise 50 cycles later.
//    -> FSM advances only on the re-rise.
//  6 Reset mid-packet: assert rst_n=0 during byte 3.
//    -> all outputs at reset values immediately, async; after release no trmt until a new snd_cmd.

Source files
------------

// File: rtl/cmd_packet_tx.sv
// cmd_packet_tx: frames a latched 16-bit command as SYNC, cmd_hi, cmd_lo[, checksum]
// and feeds it to a byte-oriented UART transmitter, pacing on the rising edge of tx_done.
// Reports completion (cmd_snt) or a stalled transmitter (tx_err) as sticky flags.
module cmd_packet_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter bit          CHK_EN    = 1'b1,
    parameter logic [15:0] TIMEOUT   = 16'd30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        tx_done,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        cmd_snt,
    output logic        tx_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    // Index of the final byte of the packet; the checksum byte is optional.
    localparam logic [1:0]  LAST     = CHK_EN ? 2'd3 : 2'd2;
    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] cmd_reg_q, cmd_reg_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        cmd_snt_q, cmd_snt_d;
    logic        tx_err_q, tx_err_d;
    logic        tx_done_ff_q;
    logic        done_rise;

    // Packet byte selector: SYNC, command high, command low, inverted 8-bit sum.
    function automatic logic [7:0] pkt_byte(input logic [1:0] idx, input logic [15:0] c);
        logic [8:0] sum;
        sum = {1'b0, c[15:8]} + {1'b0, c[7:0]};
        case (idx)
            2'd0:    pkt_byte = SYNC_BYTE;
            2'd1:    pkt_byte = c[15:8];
            2'd2:    pkt_byte = c[7:0];
            default: pkt_byte = ~sum[7:0];
        endcase
    endfunction

    // Only a fresh low-to-high transition of tx_done counts; a level left high is ignored.
    assign done_rise = tx_done & ~tx_done_ff_q;

    // Next-state and datapath decode; every target defaults to holding its value.
    always_comb begin
        state_d    = state_q;
        cmd_reg_d  = cmd_reg_q;
        byte_idx_d = byte_idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        tx_data_d  = tx_data_q;
        cmd_snt_d  = cmd_snt_q;
        tx_err_d   = tx_err_q;

        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    cmd_reg_d  = cmd;
                    byte_idx_d = '0;
                    cmd_snt_d  = 1'b0;
                    tx_err_d   = 1'b0;
                    tx_data_d  = SYNC_BYTE;
                    state_d    = LOAD;
                end
            end

            LOAD: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end

            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // A rise arriving on the timeout cycle still counts as success.
                if (done_rise) begin
                    if (byte_idx_q == LAST) begin
                        cmd_snt_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_data_d  = pkt_byte(byte_idx_q + 2'd1, cmd_reg_q);
                        state_d    = LOAD;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_reg_q    <= '0;
            byte_idx_q   <= '0;
            tmo_cnt_q    <= '0;
            tx_data_q    <= '0;
            cmd_snt_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            tx_done_ff_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_reg_q    <= cmd_reg_d;
            byte_idx_q   <= byte_idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_data_q    <= tx_data_d;
            cmd_snt_q    <= cmd_snt_d;
            tx_err_q     <= tx_err_d;
            tx_done_ff_q <= tx_done;
        end
    end

    assign trmt    = (state_q == LOAD);
    assign busy    = (state_q != IDLE);
    assign tx_data = tx_data_q;
    assign cmd_snt = cmd_snt_q;
    assign tx_err  = tx_err_q;

endmodule

// File: tb/tb_cmd_packet_tx.sv
// tb_cmd_packet_tx: drives cmd_packet_tx against a behavioural transmitter that
// captures each byte on trmt and raises tx_done a fixed number of cycles later.
module tb_cmd_packet_tx;

    localparam int unsigned BYTE_CYC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        cmd_snt;
    logic        tx_err;

    int          total = 0;
    int          bad = 0;
    int          trmt_cnt = 0;
    int          proto_err = 0;
    logic [7:0]  cap_q[$];
    int          mode = 0;          // 0 normal, 1 never completes, 2 tx_done follows man_done
    logic        man_done = 1'b0;

    typedef struct {
        logic [15:0] c;
        logic [7:0]  chk;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    cmd_packet_tx #(
        .SYNC_BYTE(8'hA5),
        .CHK_EN(1'b1),
        .TIMEOUT(16'd100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .snd_cmd(snd_cmd),
        .cmd(cmd),
        .tx_done(tx_done),
        .trmt(trmt),
        .tx_data(tx_data),
        .busy(busy),
        .cmd_snt(cmd_snt),
        .tx_err(tx_err)
    );

    // Behavioural transmitter: records bytes, clears tx_done on trmt, sets it BYTE_CYC later.
    initial begin
        int unsigned cnt;
        cnt = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt) begin
                cap_q.push_back(tx_data);
                trmt_cnt++;
                if (mode == 0 && cnt > 0) proto_err++;
                if (mode != 2) begin
                    tx_done = 1'b0;
                    cnt = (mode == 0) ? BYTE_CYC : 0;
                end
            end else if (mode == 0 && cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
            if (mode == 2) tx_done = man_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_chk(input logic [15:0] c);
        logic [8:0] s;
        s = {1'b0, c[15:8]} + {1'b0, c[7:0]};
        return ~s[7:0];
    endfunction

    task automatic clear_cap();
        cap_q.delete();
        trmt_cnt = 0;
    endtask

    // Pulse snd_cmd for one cycle; returns at the following negedge (+1) with cmd scrambled.
    task automatic send(input logic [15:0] c);
        @(negedge clk); #1;
        cmd = c;
        snd_cmd = 1'b1;
        @(negedge clk); #1;
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_trmt(input int target, input int max);
        int n;
        n = 0;
        while (trmt_cnt < target && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_trmt", {31'd0, trmt_cnt >= target}, 32'd1);
    endtask

    task automatic check_pkt(input string name, input logic [15:0] c, input logic [7:0] chk);
        logic [7:0] e[4];
        e[0] = 8'hA5;
        e[1] = c[15:8];
        e[2] = c[7:0];
        e[3] = chk;
        check({name, " count"}, cap_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s byte%0d", name, i),
                  (i < cap_q.size()) ? {24'd0, cap_q[i]} : 32'hDEAD, {24'd0, e[i]});
        end
        check({name, " cmd_snt"}, {31'd0, cmd_snt}, 32'd1);
        check({name, " tx_err"}, {31'd0, tx_err}, 32'd0);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, " trmt"}, {31'd0, trmt}, 32'd0);
        check({name, " tx_data"}, {24'd0, tx_data}, 32'd0);
        check({name, " busy"}, {31'd0, busy}, 32'd0);
        check({name, " cmd_snt"}, {31'd0, cmd_snt}, 32'd0);
        check({name, " tx_err"}, {31'd0, tx_err}, 32'd0);
    endtask

    initial begin
        int busy_hi;
        int saved;
        logic [15:0] rc;

        vecs[0] = '{16'hFF02, 8'hFE};
        vecs[1] = '{16'h0000, 8'hFF};
        vecs[2] = '{16'h8080, 8'hFF};
        vecs[3] = '{16'hABCD, 8'h87};
        vecs[4] = '{16'h00FF, 8'h00};

        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic packet with first-byte latency.
        clear_cap();
        send(16'h1234);
        check("lat busy", {31'd0, busy}, 32'd1);
        check("lat trmt", {31'd0, trmt}, 32'd1);
        check("lat tx_data", {24'd0, tx_data}, 32'hA5);
        check("lat cmd_snt", {31'd0, cmd_snt}, 32'd0);
        wait_idle(1000);
        check_pkt("basic", 16'h1234, 8'hB9);

        // Checksum table, including carry-discard cases.
        for (int i = 0; i < 5; i++) begin
            clear_cap();
            send(vecs[i].c);
            wait_idle(1000);
            check_pkt($sformatf("vec%0d", i), vecs[i].c, vecs[i].chk);
        end

        // Random commands against the reference checksum.
        for (int i = 0; i < 12; i++) begin
            rc = 16'($urandom);
            clear_cap();
            send(rc);
            wait_idle(1000);
            check_pkt($sformatf("rnd%0d", i), rc, model_chk(rc));
        end

        // snd_cmd while busy is ignored.
        clear_cap();
        send(16'h1234);
        wait_trmt(2, 500);
        repeat (5) @(negedge clk);
        #1;
        cmd = 16'hBEEF;
        snd_cmd = 1'b1;
        @(negedge clk); #1;
        snd_cmd = 1'b0;
        wait_idle(1000);
        check_pkt("busydrop", 16'h1234, 8'hB9);

        // Silent transmitter: abort exactly TIMEOUT cycles after WAIT entry.
        mode = 1;
        clear_cap();
        send(16'h5555);
        check("tmo trmt", {31'd0, trmt}, 32'd1);
        busy_hi = 0;
        repeat (100) begin
            @(negedge clk); #1;
            if (busy) busy_hi++;
        end
        check("tmo busy cycles", busy_hi, 32'd100);
        @(negedge clk); #1;
        check("tmo busy", {31'd0, busy}, 32'd0);
        check("tmo tx_err", {31'd0, tx_err}, 32'd1);
        check("tmo cmd_snt", {31'd0, cmd_snt}, 32'd0);
        check("tmo trmt count", trmt_cnt, 32'd1);

        // Next accepted command clears tx_err.
        mode = 0;
        clear_cap();
        send(16'h1234);
        check("clr tx_err", {31'd0, tx_err}, 32'd0);
        wait_idle(1000);
        check_pkt("after_tmo", 16'h1234, 8'hB9);

        // Stale tx_done level must not advance the FSM.
        mode = 2;
        man_done = 1'b1;
        clear_cap();
        send(16'hC3A1);
        @(negedge clk); #1;
        man_done = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        check("stale trmt count", trmt_cnt, 32'd1);
        check("stale busy", {31'd0, busy}, 32'd1);
        man_done = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("stale rerise trmt", trmt_cnt, 32'd2);
        for (int i = 0; i < 3; i++) begin
            man_done = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            man_done = 1'b1;
            repeat (3) @(negedge clk);
            #1;
        end
        wait_idle(500);
        check_pkt("stale", 16'hC3A1, model_chk(16'hC3A1));
        mode = 0;

        // Asynchronous reset during byte 3.
        clear_cap();
        send(16'h1234);
        wait_trmt(3, 500);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saved = trmt_cnt;
        repeat (200) @(negedge clk);
        #1;
        check("midrst no trmt", trmt_cnt, saved);
        check("midrst idle", {31'd0, busy}, 32'd0);
        clear_cap();
        send(16'h0F0F);
        wait_idle(1000);
        check_pkt("post_rst", 16'h0F0F, model_chk(16'h0F0F));

        check("protocol early trmt", proto_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
